// File: rtl/uoe_pkg.sv
// Shared definitions for the UDP offload path: FSM states, tuser field layout and CHDR helpers.
package uoe_pkg;

  typedef enum logic [2:0] {StHdr, StLook, StEmit, StFwd, StDrop} uoe_state_e;

  // tuser layout shared with the packet generator
  localparam int unsigned TuserMacLsb    = 0;
  localparam int unsigned TuserIpLsb     = 48;
  localparam int unsigned TuserUdpDstLsb = 80;
  localparam int unsigned TuserUdpSrcLsb = 96;
  localparam int unsigned TuserW         = 112;

  // Route entry payload {port, ip, mac}; the valid bit is kept alongside
  localparam int unsigned RouteDataW = TuserUdpSrcLsb;

  function automatic logic [15:0] chdr_get_dst_epid(input logic [63:0] hdr);
    return hdr[15:0];
  endfunction

  function automatic logic [15:0] chdr_get_length(input logic [63:0] hdr);
    return hdr[31:16];
  endfunction

endpackage

// File: rtl/uoe_route_table.sv
// 1W1R synchronous route RAM, read-first on same-index collision; only valid bits are reset.
module uoe_route_table
  import uoe_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic                  wr_vld_i,
  input  logic [RouteDataW-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_vld_o,
  output logic [RouteDataW-1:0] rd_data_o
);

  localparam int unsigned NumEntries = 2 ** IDX_W;

  logic [RouteDataW-1:0] mem_q [NumEntries];
  logic [NumEntries-1:0] vld_q;
  logic                  rd_vld_q;
  logic [RouteDataW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (rd_en_i) begin
        rd_vld_q <= vld_q[rd_idx_i];
      end
      if (wr_en_i) begin
        vld_q[wr_idx_i] <= wr_vld_i;
      end
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uoe_route_lookup.sv
// Looks up the CHDR dst EPID in the route table and forwards each packet with a per-packet
// UDP/IP/MAC tuser; packets without a valid route are dropped and counted.
module uoe_route_lookup
  import uoe_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       my_udp_port,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_wr_idx,
  input  logic              cfg_wr_vld,
  input  logic [47:0]       cfg_wr_mac,
  input  logic [31:0]       cfg_wr_ip,
  input  logic [15:0]       cfg_wr_port,
  input  logic [63:0]       s_tdata,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [63:0]       m_tdata,
  output logic [TuserW-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [31:0]       drop_count
);

  uoe_state_e            state_q, state_d;
  logic [63:0]           hdr_q, hdr_d;
  logic                  hdr_last_q, hdr_last_d;
  logic [TuserW-1:0]     tuser_q, tuser_d;
  logic [31:0]           drop_q, drop_d;

  logic                  rd_en;
  logic                  rd_vld;
  logic [RouteDataW-1:0] rd_data;
  logic [15:0]           hdr_epid;
  logic                  hit;

  assign rd_en    = (state_q == StHdr) && s_tvalid;
  assign hdr_epid = chdr_get_dst_epid(hdr_q);
  // EPIDs beyond the table depth can never match, even if the low bits index a valid entry
  assign hit      = rd_vld && ((hdr_epid >> IDX_W) == 16'd0);

  uoe_route_table #(
    .IDX_W(IDX_W)
  ) u_route_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cfg_wr_en),
    .wr_idx_i (cfg_wr_idx),
    .wr_vld_i (cfg_wr_vld),
    .wr_data_i({cfg_wr_port, cfg_wr_ip, cfg_wr_mac}),
    .rd_en_i  (rd_en),
    .rd_idx_i (s_tdata[IDX_W-1:0]),
    .rd_vld_o (rd_vld),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHdr;
      hdr_q      <= '0;
      hdr_last_q <= 1'b0;
      tuser_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      hdr_last_q <= hdr_last_d;
      tuser_q    <= tuser_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    hdr_last_d = hdr_last_q;
    tuser_d    = tuser_q;
    drop_d     = drop_q;
    unique case (state_q)
      StHdr: begin
        if (s_tvalid) begin
          hdr_d      = s_tdata;
          hdr_last_d = s_tlast;
          state_d    = StLook;
        end
      end
      StLook: begin
        if (hit) begin
          tuser_d = {my_udp_port, rd_data};
          state_d = StEmit;
        end else begin
          drop_d  = drop_q + 32'd1;
          state_d = hdr_last_q ? StHdr : StDrop;
        end
      end
      StEmit: begin
        if (m_tready) begin
          state_d = hdr_last_q ? StHdr : StFwd;
        end
      end
      StFwd: begin
        if (s_tvalid && m_tready && s_tlast) begin
          state_d = StHdr;
        end
      end
      StDrop: begin
        if (s_tvalid && s_tlast) begin
          state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = hdr_q;
    m_tlast  = 1'b0;
    unique case (state_q)
      StHdr:  s_tready = 1'b1;
      StLook: s_tready = 1'b0;
      StEmit: begin
        m_tvalid = 1'b1;
        m_tlast  = hdr_last_q;
      end
      StFwd: begin
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tlast  = s_tlast;
        s_tready = m_tready;
      end
      StDrop: s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
  end

  assign m_tuser    = tuser_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uoe_route_lookup.sv
// Randomized self-checking bench for uoe_route_lookup against a packet-level stream model.
module tb_uoe_route_lookup;

  logic         clk;
  logic         rst;
  logic [15:0]  my_udp_port;
  logic         cfg_wr_en;
  logic [3:0]   cfg_wr_idx;
  logic         cfg_wr_vld;
  logic [47:0]  cfg_wr_mac;
  logic [31:0]  cfg_wr_ip;
  logic [15:0]  cfg_wr_port;
  logic [63:0]  s_tdata;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  m_tdata;
  logic [111:0] m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  drop_count;

  uoe_route_lookup #(
    .IDX_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .my_udp_port(my_udp_port),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_wr_idx (cfg_wr_idx),
    .cfg_wr_vld (cfg_wr_vld),
    .cfg_wr_mac (cfg_wr_mac),
    .cfg_wr_ip  (cfg_wr_ip),
    .cfg_wr_port(cfg_wr_port),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .drop_count (drop_count)
  );

  typedef struct {
    logic [63:0]  d;
    logic         l;
    logic [111:0] u;
  } beat_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: route table, expected output stream, expected drop count
  logic         mvld  [16];
  logic [47:0]  mmac  [16];
  logic [31:0]  mip   [16];
  logic [15:0]  mport [16];
  beat_t        exp_q [$];
  int unsigned  exp_drop = 0;
  bit           in_pkt   = 0;
  bit           cur_hit  = 0;
  logic [111:0] cur_tuser;
  int unsigned  out_cnt  = 0;

  bit           bp_en = 0;
  bit           gap_en = 0;
  bit           lit_user_en = 0;
  logic [111:0] lit_user;
  bit           lit_ip_en = 0;
  logic [31:0]  lit_ip;
  bit           lit_last_en = 0;
  logic [31:0]  ip_a, ip_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Model update and output compare, sampled mid-cycle
  initial begin
    logic [15:0]  epid;
    bit           prev_stall;
    logic [63:0]  prev_d;
    logic [111:0] prev_u;
    beat_t        e;
    prev_stall = 0;
    prev_d     = '0;
    prev_u     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 16; i++) mvld[i] = 1'b0;
        exp_q.delete();
        exp_drop   = 0;
        in_pkt     = 0;
        cur_hit    = 0;
        prev_stall = 0;
      end else begin
        if (s_tvalid && s_tready) begin
          if (!in_pkt) begin
            epid      = s_tdata[15:0];
            cur_hit   = (epid < 16) && mvld[epid[3:0]];
            cur_tuser = {my_udp_port, mport[epid[3:0]], mip[epid[3:0]], mmac[epid[3:0]]};
            if (!cur_hit) exp_drop++;
          end
          if (cur_hit) exp_q.push_back('{d: s_tdata, l: s_tlast, u: cur_tuser});
          in_pkt = !s_tlast;
        end
        // table writes land after this cycle's lookup (read-first)
        if (cfg_wr_en) begin
          mvld[cfg_wr_idx]  = cfg_wr_vld;
          mmac[cfg_wr_idx]  = cfg_wr_mac;
          mip[cfg_wr_idx]   = cfg_wr_ip;
          mport[cfg_wr_idx] = cfg_wr_port;
        end
        if (prev_stall) begin
          chk("stall_valid", 128'(m_tvalid), 128'(1'b1));
          chk("stall_tdata", 128'(m_tdata), 128'(prev_d));
          chk("stall_tuser", 128'(m_tuser), 128'(prev_u));
        end
        if (m_tvalid && m_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'(m_tdata), 128'(0));
            if (m_tdata === 64'd0) begin
              bad++;
              $display("FAIL unexpected_beat: got zero beat expected none");
            end
          end else begin
            e = exp_q.pop_front();
            chk("tdata", 128'(m_tdata), 128'(e.d));
            chk("tlast", 128'(m_tlast), 128'(e.l));
            chk("tuser", 128'(m_tuser), 128'(e.u));
          end
          if (lit_user_en) chk("lit_tuser", 128'(m_tuser), 128'(lit_user));
          if (lit_ip_en)   chk("lit_ip", 128'(m_tuser[79:48]), 128'(lit_ip));
          if (lit_last_en) chk("lit_tlast", 128'(m_tlast), 128'(1'b1));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d     = m_tdata;
        prev_u     = m_tuser;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int idx, input logic v, input logic [47:0] mac,
                          input logic [31:0] ip, input logic [15:0] port);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = 4'(idx);
    cfg_wr_vld  = v;
    cfg_wr_mac  = mac;
    cfg_wr_ip   = ip;
    cfg_wr_port = port;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      bad++;
      total++;
      $display("FAIL beat_accept_timeout: got no s_tready expected handshake");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] epid, input int nbeats, input bit hdr_wr,
                          input bit mid_wr);
    logic [63:0] d;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0) d = {$urandom, 16'(nbeats * 8), epid};
      else        d = {$urandom, $urandom};
      if ((b == 0 && hdr_wr) || (b == 2 && mid_wr)) begin
        cfg_wr_en  = 1'b1;
        cfg_wr_idx = 4'd3;
        cfg_wr_vld = 1'b1;
        cfg_wr_ip  = (b == 0) ? ip_a : ip_b;
      end
      send_beat(d, b == nbeats - 1);
      cfg_wr_en = 1'b0;
      if (gap_en && $urandom_range(0, 7) == 0) tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_pkt) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      bad++;
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (4) tick();
    chk("drop_count_model", 128'(drop_count), 128'(exp_drop));
  endtask

  initial begin
    int unsigned o0;
    logic [63:0] r;
    logic [15:0] ep;
    rst         = 1'b1;
    my_udp_port = 16'h003D;
    cfg_wr_en   = 1'b0;
    cfg_wr_idx  = '0;
    cfg_wr_vld  = 1'b0;
    cfg_wr_mac  = '0;
    cfg_wr_ip   = '0;
    cfg_wr_port = '0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    s_tvalid    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_s_tready", 128'(s_tready), 128'(1'b1));
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    chk("rst_m_tlast", 128'(m_tlast), 128'(1'b0));
    chk("rst_m_tuser", 128'(m_tuser), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));

    // 1: single hit packet with a fully known tuser
    wr_entry(3, 1'b1, 48'h0200_0000_00AA, 32'hC0A8_0A02, 16'hC000);
    lit_user    = 112'h003D_C000_C0A80A02_0200000000AA;
    lit_user_en = 1;
    o0 = out_cnt;
    send_pkt(16'd3, 4, 0, 0);
    drain();
    lit_user_en = 0;
    chk("t1_beats", 128'(out_cnt - o0), 128'(4));
    chk("t1_drop", 128'(drop_count), 128'(0));

    // 2: invalid entry and out-of-range EPID are both dropped
    o0 = out_cnt;
    send_pkt(16'd5, 3, 0, 0);
    send_pkt(16'h0013, 2, 0, 0);
    drain();
    chk("t2_beats", 128'(out_cnt - o0), 128'(0));
    chk("t2_drop", 128'(drop_count), 128'(2));

    // 3: back-to-back single-beat hit/miss/hit
    lit_last_en = 1;
    o0 = out_cnt;
    send_pkt(16'd3, 1, 0, 0);
    send_pkt(16'd5, 1, 0, 0);
    send_pkt(16'd3, 1, 0, 0);
    drain();
    lit_last_en = 0;
    chk("t3_beats", 128'(out_cnt - o0), 128'(2));
    chk("t3_drop", 128'(drop_count), 128'(3));

    // 4: random table, random packets, random backpressure and input gaps
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      wr_entry(i, 1'($urandom_range(0, 3) != 0), r[47:0], $urandom, r[63:48]);
    end
    bp_en  = 1;
    gap_en = 1;
    for (int p = 0; p < 100; p++) begin
      if ($urandom_range(0, 3) == 0) ep = 16'($urandom_range(16, 16'hFFFF));
      else                           ep = 16'($urandom_range(0, 15));
      send_pkt(ep, $urandom_range(1, 64), 0, 0);
    end
    drain();
    bp_en  = 0;
    gap_en = 0;

    // 5: writes colliding with the header read and mid-packet only affect the next packet
    wr_entry(3, 1'b1, 48'h0200_0000_00AA, 32'hC0A8_0A02, 16'hC000);
    tick();
    ip_a      = 32'hC0A8_0A10;
    ip_b      = 32'hC0A8_0A20;
    lit_ip    = 32'hC0A8_0A02;
    lit_ip_en = 1;
    send_pkt(16'd3, 4, 1, 1);
    drain();
    lit_ip = 32'hC0A8_0A20;
    o0 = out_cnt;
    send_pkt(16'd3, 3, 0, 0);
    drain();
    lit_ip_en = 0;
    chk("t5_beats", 128'(out_cnt - o0), 128'(3));

    // 6: reset while forwarding payload
    send_beat({32'h1234_5678, 16'd64, 16'd3}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_s_tready", 128'(s_tready), 128'(1'b1));
    chk("t6_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    chk("t6_drop", 128'(drop_count), 128'(0));
    o0 = out_cnt;
    send_pkt(16'd3, 2, 0, 0);
    drain();
    chk("t6_beats", 128'(out_cnt - o0), 128'(0));
    chk("t6_drop_after", 128'(drop_count), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
